// File: rtl/conv_pkg.sv
// Shared definitions for the K=3 rate-1/2 convolutional encoder and its Viterbi decoder counterpart.
package conv_pkg;

    localparam int K = 3;
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } enc_state_t;

    typedef logic [1:0] code_pair_t;

endpackage

// File: rtl/conv_parity.sv
// Combinational generator taps: produces the coded pair {c1,c0} from the encoder window.
module conv_parity import conv_pkg::*; #(
    parameter int K = conv_pkg::K,
    parameter logic [K-1:0] G0 = conv_pkg::G0,
    parameter logic [K-1:0] G1 = conv_pkg::G1
) (
    input  logic [K-1:0] w,
    output code_pair_t   pair
);

    assign pair = {^(w & G1), ^(w & G0)};

endmodule

// File: rtl/conv_encoder_k3.sv
// Rate-1/2 K=3 feed-forward convolutional encoder with a one-register output stage.
// Define CONV_ENC_TAIL_EN to append K-1 zero tail pairs so each frame terminates the trellis in state 0.
module conv_encoder_k3 import conv_pkg::*; #(
    parameter int K = conv_pkg::K,
    parameter logic [K-1:0] G0 = conv_pkg::G0,
    parameter logic [K-1:0] G1 = conv_pkg::G1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output code_pair_t       out_pair,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [CNT_W-1:0] frames_done
);

    enc_state_t   state;
    logic [K-2:0] sr;
    logic [K-2:0] hist;
    logic [K-1:0] w;
    code_pair_t   pair;
    logic         slot_free;
    logic         accept;
    logic         tail_step;
    logic         encode;
    logic         u;
    logic         last_now;

`ifdef CONV_ENC_TAIL_EN
    localparam int TC_W = (K > 2) ? $clog2(K - 1) : 1;
    logic [TC_W-1:0] tail_cnt;
`endif

    always_comb begin
        slot_free = !out_valid || out_ready;
        in_ready  = !rst && slot_free && (state != TAIL);
        accept    = in_valid && in_ready;
`ifdef CONV_ENC_TAIL_EN
        tail_step = (state == TAIL) && slot_free;
        last_now  = tail_step && (tail_cnt == TC_W'(K - 2));
`else
        tail_step = 1'b0;
        last_now  = accept && in_last;
`endif
        encode    = accept || tail_step;
        u         = accept ? in_bit : 1'b0;
        // IDLE starts every frame from the all-zero trellis state regardless of leftover history
        hist      = (state == IDLE) ? '0 : sr;
        w         = {u, hist};
    end

    conv_parity #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_parity (
        .w    (w),
        .pair (pair)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sr          <= '0;
            out_valid   <= 1'b0;
            out_pair    <= '0;
            out_last    <= 1'b0;
            frames_done <= '0;
`ifdef CONV_ENC_TAIL_EN
            tail_cnt    <= '0;
`endif
        end else begin
            if (out_valid && out_ready && out_last) begin
                frames_done <= frames_done + 1'b1;
            end

            // Output register only reloads when the slot is free, so a stalled pair holds steady
            if (encode) begin
                out_pair  <= pair;
                out_last  <= last_now;
                out_valid <= 1'b1;
                sr        <= {u, hist[K-2:1]};
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE, DATA: begin
                    if (accept) begin
                        if (in_last) begin
`ifdef CONV_ENC_TAIL_EN
                            state <= TAIL;
`else
                            state <= IDLE;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end
`ifdef CONV_ENC_TAIL_EN
                TAIL: begin
                    if (tail_step) begin
                        if (last_now) begin
                            state    <= IDLE;
                            tail_cnt <= '0;
                        end else begin
                            tail_cnt <= tail_cnt + 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Directed self-checking bench for conv_encoder_k3; expectations follow CONV_ENC_TAIL_EN.
module tb_conv_encoder_k3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_bit;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [1:0]  out_pair;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic [15:0] frames_done;

    int checks = 0;
    int errors = 0;
    logic [2:0] got_q[$];
    logic [2:0] exp_q[$];
    bit rand_done;

    always #5 clk = ~clk;

    conv_encoder_k3 dut (
        .clk         (clk),
        .rst         (rst),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .out_pair    (out_pair),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .frames_done (frames_done)
    );

    // Record every output handshake as {out_last, out_pair}
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back({out_last, out_pair});
    end

`ifdef CONV_ENC_TAIL_EN
    localparam int N1 = 6;
    localparam int N2 = 4;
    function automatic logic [2:0] exp1(input int i);
        case (i)
            0: return 3'b011;
            1: return 3'b001;
            2: return 3'b000;
            3: return 3'b010;
            4: return 3'b010;
            default: return 3'b111;
        endcase
    endfunction
    function automatic logic [2:0] exp2(input int i);
        case (i)
            0: return 3'b000;
            1: return 3'b011;
            2: return 3'b001;
            default: return 3'b111;
        endcase
    endfunction
`else
    localparam int N1 = 4;
    localparam int N2 = 2;
    function automatic logic [2:0] exp1(input int i);
        case (i)
            0: return 3'b011;
            1: return 3'b001;
            2: return 3'b000;
            default: return 3'b110;
        endcase
    endfunction
    function automatic logic [2:0] exp2(input int i);
        case (i)
            0: return 3'b000;
            default: return 3'b111;
        endcase
    endfunction
`endif

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_bit(input logic b, input logic last);
        bit ok;
        ok = 1'b0;
        in_bit   = b;
        in_last  = last;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL send_bit: in_ready never 1, bit %0b not accepted", b);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_count(input int n, input int limit);
        int c;
        c = 0;
        while (got_q.size() < n && c < limit) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (got_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL wait_count: got %0d pairs, required %0d", got_q.size(), n);
        end
    endtask

    task automatic send_frame1();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_pair !== 2'b00) begin errors++; $display("FAIL reset_out_pair: got %b want 00", out_pair); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        checks++; if (frames_done !== 16'd0) begin errors++; $display("FAIL reset_frames_done: got %0d want 0", frames_done); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_frame();
        logic [15:0] fd0;
        got_q.delete();
        fd0 = frames_done;
        send_frame1();
        wait_count(N1, 100);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (got_q.size() != N1) begin errors++; $display("FAIL frame_len: got %0d want %0d", got_q.size(), N1); end
        for (int i = 0; i < N1 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp1(i)) begin errors++; $display("FAIL frame_pair[%0d]: got %b want %b", i, got_q[i], exp1(i)); end
        end
        checks++; if (frames_done !== fd0 + 16'd1) begin errors++; $display("FAIL frame_frames_done: got %0d want %0d", frames_done, fd0 + 16'd1); end
    endtask

    task automatic test_stall();
        got_q.delete();
        fork
            send_frame1();
            begin
                wait_count(1, 100);
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", out_valid); end
                    checks++; if (out_pair !== 2'b01) begin errors++; $display("FAIL stall_pair: got %b want 01", out_pair); end
                    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL stall_last: got %b want 0", out_last); end
                    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_count(N1, 100);
        checks++; if (got_q.size() != N1) begin errors++; $display("FAIL stall_len: got %0d want %0d", got_q.size(), N1); end
        for (int i = 0; i < N1 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp1(i)) begin errors++; $display("FAIL stall_pair[%0d]: got %b want %b", i, got_q[i], exp1(i)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] fd0;
        bit seen;
        got_q.delete();
        fd0 = frames_done;
        send_frame1();
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_last === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL b2b_last_seen: got 0 want 1"); end
        else if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_at_last: got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        wait_count(N1 + N2, 100);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (got_q.size() != N1 + N2) begin errors++; $display("FAIL b2b_len: got %0d want %0d", got_q.size(), N1 + N2); end
        for (int i = 0; i < N1 + N2 && i < got_q.size(); i++) begin
            logic [2:0] e;
            e = (i < N1) ? exp1(i) : exp2(i - N1);
            checks++;
            if (got_q[i] !== e) begin errors++; $display("FAIL b2b_pair[%0d]: got %b want %b", i, got_q[i], e); end
        end
        checks++; if (frames_done !== fd0 + 16'd2) begin errors++; $display("FAIL b2b_frames_done: got %0d want %0d", frames_done, fd0 + 16'd2); end
    endtask

    task automatic test_reset_mid();
        got_q.delete();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
`ifdef CONV_ENC_TAIL_EN
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        wait_count(4, 100);
`else
        wait_count(2, 100);
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        checks++; if (frames_done !== 16'd0) begin errors++; $display("FAIL rstmid_frames_done: got %0d want 0", frames_done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        got_q.delete();
        send_frame1();
        wait_count(N1, 100);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (got_q.size() != N1) begin errors++; $display("FAIL rstmid_len: got %0d want %0d", got_q.size(), N1); end
        for (int i = 0; i < N1 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp1(i)) begin errors++; $display("FAIL rstmid_pair[%0d]: got %b want %b", i, got_q[i], exp1(i)); end
        end
        checks++; if (frames_done !== 16'd1) begin errors++; $display("FAIL rstmid_frames_after: got %0d want 1", frames_done); end
    endtask

    task automatic test_random();
        localparam int NF = 20;
        logic [15:0] fd0;
        logic [5:0]  bits [NF];
        int          lens [NF];
        got_q.delete();
        exp_q.delete();
        fd0 = frames_done;
        for (int f = 0; f < NF; f++) begin
            logic s1, s0, b;
            lens[f] = $urandom_range(1, 6);
            bits[f] = 6'($urandom);
            s1 = 1'b0;
            s0 = 1'b0;
            for (int i = 0; i < lens[f]; i++) begin
                logic lst;
                b = bits[f][i];
`ifdef CONV_ENC_TAIL_EN
                lst = 1'b0;
`else
                lst = (i == lens[f] - 1);
`endif
                exp_q.push_back({lst, b ^ s0, b ^ s1 ^ s0});
                s0 = s1;
                s1 = b;
            end
`ifdef CONV_ENC_TAIL_EN
            exp_q.push_back({1'b0, s0, s1 ^ s0});
            exp_q.push_back({1'b1, s1, s1});
`endif
        end
        rand_done = 1'b0;
        fork
            begin
                for (int f = 0; f < NF; f++) begin
                    for (int i = 0; i < lens[f]; i++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                        send_bit(bits[f][i], i == lens[f] - 1);
                    end
                end
                wait_count(exp_q.size(), 2000);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_pair[%0d]: got %b want %b", i, got_q[i], exp_q[i]); end
        end
        checks++; if (frames_done !== fd0 + 16'(NF)) begin errors++; $display("FAIL rand_frames_done: got %0d want %0d", frames_done, fd0 + 16'(NF)); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
